// File: rtl/countdown_timer.sv
// countdown_timer: BCD MM:SS countdown (00:00..99:59) with a one-second
// prescaler, IDLE/RUN/PAUSED/DONE control and a one-cycle expiry pulse.
module countdown_timer #(
  parameter int unsigned CLKS_PER_TICK = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] preset,
  input  logic        start,
  input  logic        stop,
  output logic [15:0] digits,
  output logic        running,
  output logic        done,
  output logic        expired
);

  localparam int unsigned PW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [PW-1:0] TERM = PW'(CLKS_PER_TICK - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSED,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   digits_q, digits_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          expired_q, expired_d;

  // Clamp each BCD digit to its legal range (seconds tens to 5, others to 9).
  function automatic logic [15:0] sanitize(input logic [15:0] p);
    logic [3:0] mt, mo, st, so;
    mt = (p[15:12] > 4'd9) ? 4'd9 : p[15:12];
    mo = (p[11:8]  > 4'd9) ? 4'd9 : p[11:8];
    st = (p[7:4]   > 4'd5) ? 4'd5 : p[7:4];
    so = (p[3:0]   > 4'd9) ? 4'd9 : p[3:0];
    return {mt, mo, st, so};
  endfunction

  // Subtract one second with BCD borrow through the four digits; 00:00 sticks.
  function automatic logic [15:0] dec_bcd(input logic [15:0] d);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = d;
    if (d != '0) begin
      if (so != 4'd0) begin
        so = so - 4'd1;
      end else begin
        so = 4'd9;
        if (st != 4'd0) begin
          st = st - 4'd1;
        end else begin
          st = 4'd5;
          if (mo != 4'd0) begin
            mo = mo - 4'd1;
          end else begin
            mo = 4'd9;
            mt = mt - 4'd1;
          end
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  // State, count, prescaler and expiry pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      digits_q  <= '0;
      presc_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      presc_q   <= presc_d;
      expired_q <= expired_d;
    end
  end

  // Next-state logic; load beats stop, stop beats start, and the prescaler
  // only advances on a RUN cycle that is not being paused or reloaded.
  always_comb begin
    state_d   = state_q;
    digits_d  = digits_q;
    presc_d   = presc_q;
    expired_d = 1'b0;
    if (load) begin
      digits_d = sanitize(preset);
      presc_d  = '0;
      state_d  = S_IDLE;
    end else if (stop) begin
      if (state_q == S_RUN) begin
        state_d = S_PAUSED;
      end
    end else begin
      unique case (state_q)
        S_IDLE, S_PAUSED: begin
          if (start && (digits_q != '0)) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (presc_q == TERM) begin
            presc_d  = '0;
            digits_d = dec_bcd(digits_q);
            if (dec_bcd(digits_q) == '0) begin
              state_d   = S_DONE;
              expired_d = 1'b1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign digits  = digits_q;
  assign running = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign expired = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed stimulus with a seconds-based reference model;
// expected outputs are queued when inputs are driven and popped after the edge.
module tb_countdown_timer;

  logic        clk;
  logic        reset;
  logic        load;
  logic [15:0] preset;
  logic        start;
  logic        stop;
  logic [15:0] digits;
  logic        running;
  logic        done;
  logic        expired;

  int checks = 0;
  int errors = 0;

  // Reference model state: count kept as total seconds, not BCD.
  int   m_st;    // 0 idle, 1 run, 2 paused, 3 done
  int   m_secs;
  int   m_pre;
  logic m_exp;

  logic [18:0] exp_q[$];

  countdown_timer #(.CLKS_PER_TICK(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .preset  (preset),
    .start   (start),
    .stop    (stop),
    .digits  (digits),
    .running (running),
    .done    (done),
    .expired (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  function automatic int clampd(input logic [3:0] v, input int lim);
    return (int'(v) > lim) ? lim : int'(v);
  endfunction

  function automatic int to_secs(input logic [15:0] p);
    return (clampd(p[15:12], 9) * 10 + clampd(p[11:8], 9)) * 60
           + clampd(p[7:4], 5) * 10 + clampd(p[3:0], 9);
  endfunction

  function automatic logic [15:0] to_bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic model_reset();
    m_st = 0; m_secs = 0; m_pre = 0; m_exp = 1'b0;
  endtask

  task automatic model_step(input logic l, input logic [15:0] p,
                            input logic sa, input logic so);
    m_exp = 1'b0;
    if (l) begin
      m_secs = to_secs(p); m_pre = 0; m_st = 0;
    end else if (so) begin
      if (m_st == 1) m_st = 2;
    end else if (sa && (m_st == 0 || m_st == 2) && m_secs != 0) begin
      m_st = 1;
    end else if (m_st == 1) begin
      if (m_pre == 3) begin
        m_pre = 0;
        m_secs = m_secs - 1;
        if (m_secs == 0) begin
          m_st = 3; m_exp = 1'b1;
        end
      end else begin
        m_pre = m_pre + 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  // One clock: drive inputs, queue the model's prediction, compare after the edge.
  task automatic cyc(input string tag, input logic l, input logic [15:0] p,
                     input logic sa, input logic so);
    logic [18:0] want, got;
    @(negedge clk);
    load = l; preset = p; start = sa; stop = so;
    model_step(l, p, sa, so);
    exp_q.push_back({to_bcd(m_secs), m_st == 1, m_st == 3, m_exp});
    @(posedge clk);
    #1;
    got  = {digits, running, done, expired};
    want = exp_q.pop_front();
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed={d=%h r=%b dn=%b x=%b} expected={d=%h r=%b dn=%b x=%b}",
             tag, got[18:3], got[2], got[1], got[0], want[18:3], want[2], want[1], want[0]);
    end
  endtask

  task automatic idle(input string tag, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(tag, 1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; preset = '0; start = 1'b0; stop = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_digits", digits, 16'h0000);
    chk("reset_flags", {13'd0, running, done, expired}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    // Basic countdown from 00:10
    cyc("t1_load", 1'b1, 16'h0010, 1'b0, 1'b0);
    cyc("t1_start", 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("t1_running", {15'd0, running}, 16'h0001);
    idle("t1_run", 4);
    chk("t1_first_tick", digits, 16'h0009);
    idle("t1_run", 35);
    chk("t1_before_zero", digits, 16'h0001);
    idle("t1_zero", 1);
    chk("t1_expire", {digits[12:0], running, done, expired}, 16'h0003);
    chk("t1_digits_zero", digits, 16'h0000);
    idle("t1_done", 1);
    chk("t1_expired_once", {13'd0, running, done, expired}, 16'h0002);
    cyc("t1_start_in_done", 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("t1_done_held", {13'd0, running, done, expired}, 16'h0002);

    // Borrow chain
    cyc("t2_load", 1'b1, 16'h1000, 1'b0, 1'b0);
    cyc("t2_start", 1'b0, 16'h0000, 1'b1, 1'b0);
    idle("t2_run", 4);
    chk("t2_borrow_1000", digits, 16'h0959);
    cyc("t2_load2", 1'b1, 16'h0100, 1'b0, 1'b0);
    cyc("t2_start2", 1'b0, 16'h0000, 1'b1, 1'b0);
    idle("t2_run2", 4);
    chk("t2_borrow_0100", digits, 16'h0059);

    // Pause and resume with prescaler retained
    cyc("t3_load", 1'b1, 16'h0005, 1'b0, 1'b0);
    cyc("t3_start", 1'b0, 16'h0000, 1'b1, 1'b0);
    idle("t3_run", 2);
    cyc("t3_stop", 1'b0, 16'h0000, 1'b0, 1'b1);
    chk("t3_paused", {15'd0, running}, 16'h0000);
    idle("t3_hold", 20);
    chk("t3_hold_digits", digits, 16'h0005);
    cyc("t3_resume", 1'b0, 16'h0000, 1'b1, 1'b0);
    idle("t3_run2", 1);
    chk("t3_not_yet", digits, 16'h0005);
    idle("t3_run2", 1);
    chk("t3_resume_tick", digits, 16'h0004);

    // Sanitization and zero guard
    cyc("t4_sanitize", 1'b1, 16'h0A7F, 1'b0, 1'b0);
    chk("t4_sanitized", digits, 16'h0959);
    cyc("t4_sanitize2", 1'b1, 16'hFFFF, 1'b0, 1'b0);
    chk("t4_sanitized_max", digits, 16'h9959);
    cyc("t4_load0", 1'b1, 16'h0000, 1'b0, 1'b0);
    cyc("t4_start0", 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("t4_zero_guard", {13'd0, running, done, expired}, 16'h0000);

    // Priority
    cyc("t5_load", 1'b1, 16'h0020, 1'b0, 1'b0);
    cyc("t5_start", 1'b0, 16'h0000, 1'b1, 1'b0);
    idle("t5_run", 1);
    cyc("t5_start_stop", 1'b0, 16'h0000, 1'b1, 1'b1);
    chk("t5_stop_wins", {15'd0, running}, 16'h0000);
    cyc("t5_restart", 1'b0, 16'h0000, 1'b1, 1'b0);
    idle("t5_run2", 1);
    cyc("t5_load_stop", 1'b1, 16'h0030, 1'b0, 1'b1);
    chk("t5_load_wins", {digits[13:0], running, done}, {14'h0030, 2'b00});
    cyc("t5_start3", 1'b0, 16'h0000, 1'b1, 1'b0);
    idle("t5_run3", 3);
    chk("t5_presc_cleared", digits, 16'h0030);
    idle("t5_run3", 1);
    chk("t5_first_tick", digits, 16'h0029);

    // Asynchronous reset mid-RUN
    cyc("t6_load", 1'b1, 16'h0100, 1'b0, 1'b0);
    cyc("t6_start", 1'b0, 16'h0000, 1'b1, 1'b0);
    idle("t6_run", 5);
    @(negedge clk);
    load = 1'b0; start = 1'b0; stop = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("t6_async_digits", digits, 16'h0000);
    chk("t6_async_running", {15'd0, running}, 16'h0000);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle("t6_after", 3);
    chk("t6_stays_idle", {digits[13:0], running, done}, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
